disp_line_writer: RTL and testbench

Producer side of the post-processing line SRAMs. Accepts the left and right final-disparity streams from the WTA stage and writes them into ping-pong line banks. When both halves of a line are in SRAM it raises `valid_final_L` / `valid_final_R` for the LR-check / hole-filling chain. It releases a bank when the consumer returns `line_ack`, and back-pressures upstream when both banks hold unconsumed lines.

---
 rtl/disp_line_writer.sv | 241 ++++++++++++++++++++++++
 tb/tb_disp_line_writer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_line_writer.sv
`default_nettype none
// ============================================================================
//  Module      : disp_line_writer
//  Description : Writes the left/right final-disparity streams from the WTA
//                stage into ping-pong line SRAM banks, flags complete lines
//                to the LR-check / hole-filling consumer, recycles banks on
//                line_ack and back-pressures upstream when both banks hold
//                unconsumed lines.
//  Options     : DISP_WRITER_RANGE_CLAMP_EN - when defined, beats above
//                `range` are written as the all-ones invalid code.
//  Revision    : 1.0 - initial release
// ============================================================================
module disp_line_writer #(
  parameter int DWIDTH = 9,
  parameter int AWIDTH = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clken,
  input  logic [AWIDTH-1:0] width,
  input  logic [DWIDTH-1:0] range,
  input  logic              din_valid_L,
  input  logic              din_valid_R,
  input  logic [DWIDTH-1:0] din_L,
  input  logic [DWIDTH-1:0] din_R,
  output logic              din_ready_L,
  output logic              din_ready_R,
  input  logic              line_ack,
  output logic              wr_en_L,
  output logic              wr_en_R,
  output logic [AWIDTH-1:0] wr_addr_L,
  output logic [AWIDTH-1:0] wr_addr_R,
  output logic [DWIDTH-1:0] wr_data_L,
  output logic [DWIDTH-1:0] wr_data_R,
  output logic              wr_bank,
  output logic              rd_bank,
  output logic              valid_final_L,
  output logic              valid_final_R,
  output logic              drop_err
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    WAIT_BANK = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [AWIDTH-1:0] col_L;
  logic [AWIDTH-1:0] col_R;
  logic [AWIDTH-1:0] width_q;
  logic              wb;
  logic              rb;
  logic [1:0]        full_cnt;
  logic [1:0]        full_nxt;

  logic              ready_L;
  logic              ready_R;
  logic              acc_L;
  logic              acc_R;
  logic              drop_L;
  logic              drop_R;
  logic              commit;
  logic              ack_eff;

  logic [DWIDTH-1:0] data_L;
  logic [DWIDTH-1:0] data_R;

`ifdef DISP_WRITER_RANGE_CLAMP_EN
  // Out-of-range disparities are replaced by the invalid code before writing.
  assign data_L = (din_L > range) ? {DWIDTH{1'b1}} : din_L;
  assign data_R = (din_R > range) ? {DWIDTH{1'b1}} : din_R;
`else
  // Range input has no function in this build; data passes straight through.
  logic unused_range;
  assign unused_range = ^range;
  assign data_L       = din_L;
  assign data_R       = din_R;
`endif

  // An ack only counts while enabled and when there is a line to release.
  assign ack_eff = clken & line_ack & (full_cnt != 2'd0);

  // Next-state, readys, beat acceptance and commit decode.
  always_comb begin
    state_nxt = state;
    ready_L   = 1'b0;
    ready_R   = 1'b0;
    commit    = 1'b0;
    full_nxt  = full_cnt;
    acc_L     = 1'b0;
    acc_R     = 1'b0;
    drop_L    = 1'b0;
    drop_R    = 1'b0;

    // Readys are forced low while in reset or while the clock enable is low.
    if (rst && clken) begin
      case (state)
        IDLE: begin
          ready_L = (width != '0) && (full_cnt != 2'd2);
          ready_R = (width != '0) && (full_cnt != 2'd2);
        end
        WRITE: begin
          // A stream that has delivered its full line waits for the other.
          ready_L = (col_L < width_q);
          ready_R = (col_R < width_q);
          commit  = (col_L == width_q) && (col_R == width_q);
        end
        default: begin
          ready_L = 1'b0;
          ready_R = 1'b0;
        end
      endcase
    end

    acc_L  = din_valid_L & ready_L;
    acc_R  = din_valid_R & ready_R;
    drop_L = clken & din_valid_L & ~ready_L;
    drop_R = clken & din_valid_R & ~ready_R;

    // Commit and ack in the same cycle cancel in the line count.
    case ({commit, ack_eff})
      2'b10:   full_nxt = full_cnt + 2'd1;
      2'b01:   full_nxt = full_cnt - 2'd1;
      default: full_nxt = full_cnt;
    endcase

    if (clken) begin
      case (state)
        IDLE: begin
          if (acc_L || acc_R) begin
            state_nxt = WRITE;
          end
        end
        WRITE: begin
          if (commit) begin
            state_nxt = (full_nxt == 2'd2) ? WAIT_BANK : IDLE;
          end
        end
        WAIT_BANK: begin
          if (ack_eff) begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign din_ready_L = ready_L;
  assign din_ready_R = ready_R;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else if (clken) begin
      state <= state_nxt;
    end
  end

  // Column counters, latched line width, bank pointers and line count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_L    <= '0;
      col_R    <= '0;
      width_q  <= '0;
      wb       <= 1'b0;
      rb       <= 1'b0;
      full_cnt <= 2'd0;
    end else if (clken) begin
      // Width is captured on the first beat and held for the whole line.
      if ((state == IDLE) && (acc_L || acc_R)) begin
        width_q <= width;
      end
      if (commit) begin
        col_L <= '0;
        col_R <= '0;
        wb    <= ~wb;
      end else begin
        if (acc_L) begin
          col_L <= col_L + 1'b1;
        end
        if (acc_R) begin
          col_R <= col_R + 1'b1;
        end
      end
      if (ack_eff) begin
        rb <= ~rb;
      end
      full_cnt <= full_nxt;
    end
  end

  // SRAM write port: one registered pulse per accepted beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en_L   <= 1'b0;
      wr_en_R   <= 1'b0;
      wr_addr_L <= '0;
      wr_addr_R <= '0;
      wr_data_L <= '0;
      wr_data_R <= '0;
    end else begin
      // Strobes track acceptance every cycle so they never stretch while
      // the clock enable is low (acceptance is already gated by clken).
      wr_en_L <= acc_L;
      wr_en_R <= acc_R;
      if (acc_L) begin
        wr_addr_L <= col_L;
        wr_data_L <= data_L;
      end
      if (acc_R) begin
        wr_addr_R <= col_R;
        wr_data_R <= data_R;
      end
    end
  end

  // Line-available flags and the sticky dropped-beat error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_final_L <= 1'b0;
      valid_final_R <= 1'b0;
      drop_err      <= 1'b0;
    end else if (clken) begin
      valid_final_L <= (full_cnt != 2'd0);
      valid_final_R <= (full_cnt != 2'd0);
      if (drop_L || drop_R) begin
        drop_err <= 1'b1;
      end
    end
  end

  assign wr_bank = wb;
  assign rd_bank = rb;

endmodule
`default_nettype wire

// File: tb/tb_disp_line_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_disp_line_writer
//  Description : Directed self-checking bench for disp_line_writer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_disp_line_writer;

  localparam int DW = 9;
  localparam int AW = 11;

`ifdef DISP_WRITER_RANGE_CLAMP_EN
  localparam logic [DW-1:0] EXP_CLAMP = 9'h1FF;
`else
  localparam logic [DW-1:0] EXP_CLAMP = 9'd100;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          clken;
  logic [AW-1:0] width;
  logic [DW-1:0] range;
  logic          din_valid_L;
  logic          din_valid_R;
  logic [DW-1:0] din_L;
  logic [DW-1:0] din_R;
  logic          din_ready_L;
  logic          din_ready_R;
  logic          line_ack;
  logic          wr_en_L;
  logic          wr_en_R;
  logic [AW-1:0] wr_addr_L;
  logic [AW-1:0] wr_addr_R;
  logic [DW-1:0] wr_data_L;
  logic [DW-1:0] wr_data_R;
  logic          wr_bank;
  logic          rd_bank;
  logic          valid_final_L;
  logic          valid_final_R;
  logic          drop_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  disp_line_writer #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .clken         (clken),
    .width         (width),
    .range         (range),
    .din_valid_L   (din_valid_L),
    .din_valid_R   (din_valid_R),
    .din_L         (din_L),
    .din_R         (din_R),
    .din_ready_L   (din_ready_L),
    .din_ready_R   (din_ready_R),
    .line_ack      (line_ack),
    .wr_en_L       (wr_en_L),
    .wr_en_R       (wr_en_R),
    .wr_addr_L     (wr_addr_L),
    .wr_addr_R     (wr_addr_R),
    .wr_data_L     (wr_data_L),
    .wr_data_R     (wr_data_R),
    .wr_bank       (wr_bank),
    .rd_bank       (rd_bank),
    .valid_final_L (valid_final_L),
    .valid_final_R (valid_final_R),
    .drop_err      (drop_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_en_L"},   32'(wr_en_L),       32'd0);
    check({tag, "_wr_en_R"},   32'(wr_en_R),       32'd0);
    check({tag, "_wr_addr_L"}, 32'(wr_addr_L),     32'd0);
    check({tag, "_wr_addr_R"}, 32'(wr_addr_R),     32'd0);
    check({tag, "_wr_data_L"}, 32'(wr_data_L),     32'd0);
    check({tag, "_wr_data_R"}, 32'(wr_data_R),     32'd0);
    check({tag, "_wr_bank"},   32'(wr_bank),       32'd0);
    check({tag, "_rd_bank"},   32'(rd_bank),       32'd0);
    check({tag, "_vf_L"},      32'(valid_final_L), 32'd0);
    check({tag, "_vf_R"},      32'(valid_final_R), 32'd0);
    check({tag, "_rdy_L"},     32'(din_ready_L),   32'd0);
    check({tag, "_rdy_R"},     32'(din_ready_R),   32'd0);
    check({tag, "_drop_err"},  32'(drop_err),      32'd0);
  endtask

  initial begin
    rst         = 1'b0;
    clken       = 1'b1;
    width       = 11'd8;
    range       = 9'd64;
    din_valid_L = 1'b0;
    din_valid_R = 1'b0;
    din_L       = '0;
    din_R       = '0;
    line_ack    = 1'b0;

    // Reset state
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b1;
    #1;
    check("idle_rdy_L", 32'(din_ready_L), 32'd1);

    // Line 0: 8 L and 8 R beats back-to-back into bank 0
    din_valid_L = 1'b1;
    din_valid_R = 1'b1;
    for (int k = 0; k < 8; k++) begin
      din_L = 9'(10 + k);
      din_R = 9'(20 + k);
      tick();
      check("l0_wr_en_L",   32'(wr_en_L),   32'd1);
      check("l0_wr_addr_L", 32'(wr_addr_L), 32'(k));
      check("l0_wr_data_L", 32'(wr_data_L), 32'(10 + k));
      check("l0_wr_addr_R", 32'(wr_addr_R), 32'(k));
      check("l0_wr_data_R", 32'(wr_data_R), 32'(20 + k));
      check("l0_wr_bank",   32'(wr_bank),   32'd0);
    end
    din_valid_L = 1'b0;
    din_valid_R = 1'b0;
    check("l0_done_rdy_L", 32'(din_ready_L),   32'd0);
    check("l0_done_rdy_R", 32'(din_ready_R),   32'd0);
    check("l0_vf_n",       32'(valid_final_L), 32'd0);
    tick();  // commit edge
    check("l0_commit_wr_en", 32'(wr_en_L),       32'd0);
    check("l0_commit_vf",    32'(valid_final_L), 32'd0);
    check("l0_commit_wb",    32'(wr_bank),       32'd1);
    check("l0_commit_rdy",   32'(din_ready_L),   32'd1);
    tick();
    check("l0_vf_L",   32'(valid_final_L), 32'd1);
    check("l0_vf_R",   32'(valid_final_R), 32'd1);
    check("l0_rdbank", 32'(rd_bank),       32'd0);

    // Line 1 with skew: all L first, then all R, into bank 1
    din_valid_L = 1'b1;
    for (int k = 0; k < 8; k++) begin
      din_L = 9'(30 + k);
      tick();
      check("l1_wr_addr_L", 32'(wr_addr_L), 32'(k));
      check("l1_wr_bank",   32'(wr_bank),   32'd1);
      check("l1_wr_en_R",   32'(wr_en_R),   32'd0);
    end
    check("skew_rdy_L", 32'(din_ready_L), 32'd0);
    check("skew_rdy_R", 32'(din_ready_R), 32'd1);
    check("skew_drop0", 32'(drop_err),    32'd0);
    din_L = 9'd99;  // ninth L beat, offered while not ready
    tick();
    check("skew_drop1",   32'(drop_err), 32'd1);
    check("skew_no_wr_L", 32'(wr_en_L),  32'd0);
    din_valid_L = 1'b0;
    din_valid_R = 1'b1;
    for (int k = 0; k < 8; k++) begin
      din_R = 9'(40 + k);
      tick();
      check("l1_wr_addr_R", 32'(wr_addr_R), 32'(k));
      check("l1_wr_data_R", 32'(wr_data_R), 32'(40 + k));
    end
    din_valid_R = 1'b0;
    tick();  // commit: both banks now full
    check("full2_cnt",   32'(dut.full_cnt),  32'd2);
    check("full2_rdy_L", 32'(din_ready_L),   32'd0);
    check("full2_rdy_R", 32'(din_ready_R),   32'd0);
    check("full2_wb",    32'(wr_bank),       32'd0);
    check("full2_vf",    32'(valid_final_L), 32'd1);
    tick();
    check("full2_hold_rdy", 32'(din_ready_L), 32'd0);

    // One ack releases bank 0
    line_ack = 1'b1;
    tick();
    line_ack = 1'b0;
    check("ack1_rdbank", 32'(rd_bank),       32'd1);
    check("ack1_rdy_L",  32'(din_ready_L),   32'd1);
    check("ack1_rdy_R",  32'(din_ready_R),   32'd1);
    check("ack1_cnt",    32'(dut.full_cnt),  32'd1);
    tick();
    check("ack1_vf", 32'(valid_final_L), 32'd1);

    // Line 2 into bank 0; width changes mid-line; commit coincides with ack
    din_valid_L = 1'b1;
    din_valid_R = 1'b1;
    for (int k = 0; k < 8; k++) begin
      din_L = 9'(50 + k);
      din_R = 9'(60 + k);
      tick();
      if (k == 0) width = 11'd3;
      check("l2_wr_en_L",   32'(wr_en_L),   32'd1);
      check("l2_wr_addr_L", 32'(wr_addr_L), 32'(k));
      check("l2_wr_bank",   32'(wr_bank),   32'd0);
    end
    din_valid_L = 1'b0;
    din_valid_R = 1'b0;
    line_ack    = 1'b1;
    tick();  // commit and ack together
    line_ack = 1'b0;
    check("coin_cnt",    32'(dut.full_cnt),  32'd1);
    check("coin_wb",     32'(wr_bank),       32'd1);
    check("coin_rb",     32'(rd_bank),       32'd0);
    check("coin_vf",     32'(valid_final_R), 32'd1);
    tick();
    check("coin_vf2", 32'(valid_final_L), 32'd1);

    // Reset after 3 beats of a line
    width       = 11'd8;
    din_valid_L = 1'b1;
    din_valid_R = 1'b1;
    for (int k = 0; k < 3; k++) begin
      din_L = 9'(1 + k);
      din_R = 9'(2 + k);
      tick();
      check("pre_rst_wb", 32'(wr_bank), 32'd1);
    end
    rst         = 1'b0;
    din_valid_L = 1'b0;
    din_valid_R = 1'b0;
    #1;
    check_all_zero("midrst");
    tick();
    rst = 1'b1;
    #1;
    check("post_rst_rdy", 32'(din_ready_L),   32'd1);
    check("post_rst_vf",  32'(valid_final_L), 32'd0);

    // Ack with nothing full is ignored
    line_ack = 1'b1;
    tick();
    line_ack = 1'b0;
    check("ack0_rb",  32'(rd_bank),      32'd0);
    check("ack0_cnt", 32'(dut.full_cnt), 32'd0);

    // Zero width holds readys low in IDLE
    width = 11'd0;
    #1;
    check("w0_rdy_L", 32'(din_ready_L), 32'd0);
    check("w0_rdy_R", 32'(din_ready_R), 32'd0);
    width = 11'd8;

    // New line after reset: address 0, bank 0, range boundary on data
    din_valid_L = 1'b1;
    din_valid_R = 1'b1;
    din_L       = 9'd100;
    din_R       = 9'd64;
    tick();
    check("new_addr_L", 32'(wr_addr_L), 32'd0);
    check("new_bank",   32'(wr_bank),   32'd0);
    check("clamp_L",    32'(wr_data_L), 32'(EXP_CLAMP));
    check("edge_R",     32'(wr_data_R), 32'd64);

    // Clock enable low freezes everything
    din_L = 9'd5;
    din_R = 9'd6;
    clken = 1'b0;
    #1;
    check("ce0_rdy_L", 32'(din_ready_L), 32'd0);
    tick();
    check("ce0_wr_en",  32'(wr_en_L),  32'd0);
    check("ce0_drop",   32'(drop_err), 32'd0);
    clken = 1'b1;
    tick();
    check("ce1_wr_en",   32'(wr_en_L),   32'd1);
    check("ce1_addr_L",  32'(wr_addr_L), 32'd1);
    check("ce1_data_L",  32'(wr_data_L), 32'd5);
    din_valid_L = 1'b0;
    din_valid_R = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
